io_vnw_bias_seq: RTL
====================

Name: io_vnw_bias_seq

Overview:
Digital sequencer that drives the n-well (VNW) bias supply feeding the IO-ring VNW pad cells. It accepts a target bias code over a valid/ready handshake, enables the bias generator, and ramps the generator DAC code in bounded steps with a programmable dwell per step. It reports when the code has settled and ramps back to zero before disabling. It sits in the always-on pad-control domain next to the IO power-good logic.

Parameters:
CODE_W, 6, width of bias DAC code
STEP_W, 3, width of per-step increment
DWELL_W, 10, width of dwell-cycle counter
EN_DLY, 16, cycles between bias_en assertion and first ramp step
CODE_MAX, 48, highest legal target code

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level request to keep bias active
tgt_valid  in  1  new target code offered
tgt_ready  out  1  target accepted this cycle when high together with tgt_valid
tgt_code  in  CODE_W  requested bias code
step_size  in  STEP_W  code increment per step; 0 treated as 1
dwell_cyc  in  DWELL_W  cycles held at each intermediate code
bias_en  out  1  enable to the bias generator
dac_code  out  CODE_W  code driven to the bias DAC
busy  out  1  ramp or enable/disable sequence in progress
settled  out  1  dac_code equals accepted target and no ramp is pending
range_err  out  1  sticky; set when an offered target exceeds CODE_MAX

Behaviour:
- Reset (async assert, sync deassert handled upstream): bias_en=0, dac_code=0, busy=0, settled=0, range_err=0, tgt_ready=0. Internal target register=0. State=OFF.
- States: OFF, EN_WAIT, RAMP, DWELL, HOLD, RAMP_DN.
- OFF: on enable=1, set bias_en=1, clear the counter, go to EN_WAIT. busy=1 from the next cycle.
- EN_WAIT: count EN_DLY cycles, then go to HOLD. dac_code stays 0.
- HOLD: tgt_ready=1. settled=1 when dac_code==target.
  - Handshake tgt_valid&&tgt_ready with tgt_code<=CODE_MAX: latch the target. settled drops the next cycle. Go to RAMP if the new target differs from dac_code; otherwise stay.
  - tgt_code>CODE_MAX: accept (ready still high), ignore the value, set range_err. Target is unchanged.
  - enable=0 in HOLD: go to RAMP_DN.
- RAMP: compute one step per cycle entry. dac_code moves toward the target by min(step, |target-dac_code|), so it never overshoots. Arithmetic uses CODE_W+1 bits to avoid wrap at the 0 and max ends.
  - If the target is reached, go to HOLD.
  - Otherwise load the dwell counter and go to DWELL.
- DWELL: count dwell_cyc cycles, then return to RAMP. dwell_cyc=0 means return after 1 cycle.
- tgt_ready=0 in all states except HOLD; targets are never accepted mid-ramp.
- enable=0 in EN_WAIT, RAMP or DWELL: abort the current ramp immediately and go to RAMP_DN. In EN_WAIT with dac_code=0, this goes straight to OFF via RAMP_DN.
- RAMP_DN: step toward 0 using the same step/dwell rules. When dac_code==0, deassert bias_en, set busy=0 and go to OFF. The target register resets to 0.
- enable reasserted during RAMP_DN: finish the ramp-down to OFF first, then restart from OFF on the next cycle.
- busy=1 in EN_WAIT, RAMP, DWELL and RAMP_DN; busy=0 in OFF and HOLD.
- range_err clears only on reset.
- All outputs are registered; latency from the handshake to the first dac_code change is 1 cycle.

Decomposition:
- Package io_vnw_bias_pkg holds:
  - the state enum type
  - default parameter constants
  - a function computing the next code: sat_step(cur, tgt, step) returns a code clamped to tgt.
- One sub-module, io_vnw_bias_timer: a loadable down-counter with a done pulse. It is shared by the EN_WAIT and DWELL states, with width max(DWELL_W, clog2(EN_DLY+1)).

Test Plan:
- Reset, then enable=1 -> bias_en=1 on the next cycle; tgt_ready rises exactly EN_DLY+1 cycles later; dac_code=0; busy falls with tgt_ready.
- In HOLD, offer tgt_code=20, step_size=4, dwell_cyc=3 -> dac_code goes 4,8,12,16,20 with 4 cycles between codes; settled=1 after 20; tgt_ready=0 throughout.
- From 20, offer tgt_code=11 with step_size=4 -> dac_code goes 16,12,11 (no undershoot) and settled=1.
- Offer tgt_code=60 (>CODE_MAX) -> range_err=1 sticky; dac_code unchanged; settled stays 1.
- enable=0 mid-ramp at dac_code=12, step 4, dwell 0 -> dac_code goes 8,4,0; bias_en=0 after 0 is reached; state OFF.
- Assert rst_n=0 mid-DWELL -> all outputs go to 0 asynchronously in the same cycle; after release, the block is in OFF with no activity until enable is asserted.

Source files
------------

// File: rtl/io_vnw_bias_pkg.sv
// Shared types, default constants and the code-stepping helper for the
// IO-ring n-well bias sequencer.
package io_vnw_bias_pkg;

  localparam int CODE_W_DEF   = 6;
  localparam int STEP_W_DEF   = 3;
  localparam int DWELL_W_DEF  = 10;
  localparam int EN_DLY_DEF   = 16;
  localparam int CODE_MAX_DEF = 48;
  localparam int SAT_W        = 16;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EN_WAIT,
    ST_RAMP,
    ST_DWELL,
    ST_HOLD,
    ST_RAMP_DN
  } state_t;

  // Moves cur toward tgt by at most step (0 acts as 1); never passes tgt.
  // The signed difference is one bit wider than the codes so neither end wraps.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] cur,
                                                input logic [SAT_W-1:0] tgt,
                                                input logic [SAT_W-1:0] step);
    logic signed [SAT_W:0] diff;
    logic signed [SAT_W:0] stp;
    stp  = (step == '0) ? (SAT_W+1)'(1) : $signed({1'b0, step});
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > stp)       sat_step = cur + SAT_W'(stp);
    else if (-diff > stp) sat_step = cur - SAT_W'(stp);
    else                  sat_step = tgt;
  endfunction

endpackage

// File: rtl/io_vnw_bias_seq_if.sv
// Target-code handshake between the pad-control master and the bias sequencer.
interface io_vnw_bias_seq_if
  import io_vnw_bias_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
);
  logic              tgt_valid;
  logic              tgt_ready;
  logic [CODE_W-1:0] tgt_code;

  modport master (output tgt_valid, output tgt_code, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_code, output tgt_ready);
endinterface

// File: rtl/io_vnw_bias_timer.sv
// Loadable down-counter shared by the enable delay and the per-step dwell;
// done is high while the count sits at zero.
module io_vnw_bias_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/io_vnw_bias_seq.sv
// VNW bias sequencer: enables the bias generator, ramps its DAC code toward an
// accepted target in bounded steps with dwell, and ramps back to zero on release.
module io_vnw_bias_seq
  import io_vnw_bias_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int STEP_W   = STEP_W_DEF,
  parameter int DWELL_W  = DWELL_W_DEF,
  parameter int EN_DLY   = EN_DLY_DEF,
  parameter int CODE_MAX = CODE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  io_vnw_bias_seq_if.slave    tgt,
  input  logic [STEP_W-1:0]   step_size,
  input  logic [DWELL_W-1:0]  dwell_cyc,
  output logic                bias_en,
  output logic [CODE_W-1:0]   dac_code,
  output logic                busy,
  output logic                settled,
  output logic                range_err
);
  localparam int EN_CNT_W = $clog2(EN_DLY + 1);
  localparam int TMR_W    = (DWELL_W > EN_CNT_W) ? DWELL_W : EN_CNT_W;
  localparam logic [CODE_W-1:0] CODE_MAX_C = CODE_W'(CODE_MAX);
  localparam logic [TMR_W-1:0]  EN_DLY_C   = TMR_W'(EN_DLY);

  state_t            state, state_n;
  logic              bias_en_n, busy_n, settled_n, rerr_n, ready_r, ready_n;
  logic [CODE_W-1:0] dac_n, tgt_r, tgt_n, up_code, dn_code;
  logic              hs, t_load, t_dec, t_done;
  logic [TMR_W-1:0]  t_val, dwell_ext, dwell_up, dwell_dn;

  io_vnw_bias_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .done     (t_done)
  );

  assign tgt.tgt_ready = ready_r;
  assign hs      = tgt.tgt_valid && ready_r;
  assign up_code = CODE_W'(sat_step(SAT_W'(dac_code), SAT_W'(tgt_r), SAT_W'(step_size)));
  assign dn_code = CODE_W'(sat_step(SAT_W'(dac_code), '0, SAT_W'(step_size)));

  // Up-ramp spends one cycle in RAMP plus the dwell; ramp-down folds both into
  // one reload so both directions share the same step period.
  assign dwell_ext = TMR_W'(dwell_cyc);
  assign dwell_up  = (dwell_ext == '0) ? '0 : dwell_ext - TMR_W'(1);
  assign dwell_dn  = (dwell_ext == '0) ? TMR_W'(1) : dwell_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      bias_en   <= 1'b0;
      dac_code  <= '0;
      busy      <= 1'b0;
      settled   <= 1'b0;
      range_err <= 1'b0;
      ready_r   <= 1'b0;
      tgt_r     <= '0;
    end else begin
      state     <= state_n;
      bias_en   <= bias_en_n;
      dac_code  <= dac_n;
      busy      <= busy_n;
      settled   <= settled_n;
      range_err <= rerr_n;
      ready_r   <= ready_n;
      tgt_r     <= tgt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bias_en_n = bias_en;
    dac_n     = dac_code;
    busy_n    = busy;
    rerr_n    = range_err;
    tgt_n     = tgt_r;
    t_load    = 1'b0;
    t_val     = '0;
    t_dec     = 1'b0;
    case (state)
      ST_OFF: begin
        if (enable) begin
          state_n   = ST_EN_WAIT;
          bias_en_n = 1'b1;
          busy_n    = 1'b1;
          t_load    = 1'b1;
          t_val     = EN_DLY_C;
        end
      end
      ST_EN_WAIT: begin
        if (!enable) begin
          state_n = ST_RAMP_DN;
          t_load  = 1'b1;
        end else if (t_done) begin
          state_n = ST_HOLD;
          busy_n  = 1'b0;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          state_n = ST_RAMP_DN;
          busy_n  = 1'b1;
          t_load  = 1'b1;
        end else if (hs) begin
          if (tgt.tgt_code > CODE_MAX_C) begin
            rerr_n = 1'b1;
          end else begin
            tgt_n = tgt.tgt_code;
            if (tgt.tgt_code != dac_code) begin
              state_n = ST_RAMP;
              busy_n  = 1'b1;
            end
          end
        end
      end
      ST_RAMP: begin
        if (!enable) begin
          state_n = ST_RAMP_DN;
          t_load  = 1'b1;
        end else begin
          dac_n = up_code;
          if (up_code == tgt_r) begin
            state_n = ST_HOLD;
            busy_n  = 1'b0;
          end else begin
            state_n = ST_DWELL;
            t_load  = 1'b1;
            t_val   = dwell_up;
          end
        end
      end
      ST_DWELL: begin
        if (!enable) begin
          state_n = ST_RAMP_DN;
          t_load  = 1'b1;
        end else if (t_done) begin
          state_n = ST_RAMP;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_RAMP_DN: begin
        if (dac_code == '0 || (t_done && dn_code == '0)) begin
          state_n   = ST_OFF;
          dac_n     = '0;
          bias_en_n = 1'b0;
          busy_n    = 1'b0;
          tgt_n     = '0;
        end else if (t_done) begin
          dac_n  = dn_code;
          t_load = 1'b1;
          t_val  = dwell_dn;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_n = ST_OFF;
    endcase
  end

  assign ready_n   = (state_n == ST_HOLD);
  assign settled_n = (state_n == ST_HOLD) && (dac_n == tgt_n);
endmodule
